seg7_time_display: RTL and testbench

//  Consumer end of the clock's BCD digit interface: converts 24-h time digits to 12-h when fmt=1,

---
 rtl/seg7_time_display_pkg.sv | 41 ++++
 rtl/seg7_time_display_if.sv | 16 +
 rtl/seg7_time_display_bcd_to_seg7.sv | 26 ++
 rtl/seg7_time_display.sv | 174 +++++++++++++++++
 tb/tb_seg7_time_display.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_time_display_pkg.sv
// Shared definitions for the time display: segment patterns, slot indices, page codes
// and the per-frame snapshot payload.
package seg7_time_display_pkg;

    // Active-low {g,f,e,d,c,b,a} patterns
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] SLOT_0 = 2'd0;
    localparam logic [1:0] SLOT_1 = 2'd1;
    localparam logic [1:0] SLOT_2 = 2'd2;
    localparam logic [1:0] SLOT_3 = 2'd3;

    localparam logic PAGE_HM = 1'b0;
    localparam logic PAGE_MS = 1'b1;

    // Out-of-range code fed to the decoder to force a dash
    localparam logic [3:0] BCD_BAD = 4'hF;

    typedef struct packed {
        logic       fmt;
        logic       page;
        logic [1:0] hrL;
        logic [3:0] hrR;
        logic [2:0] mL;
        logic [3:0] mR;
        logic [2:0] sL;
        logic [3:0] sR;
    } snap_t;

endpackage

// File: rtl/seg7_time_display_if.sv
// BCD time digit bus from the timekeeping block plus display controls.
interface seg7_time_display_if;
    logic       fmt;
    logic [1:0] hrL;
    logic [3:0] hrR;
    logic [2:0] mL;
    logic [3:0] mR;
    logic [2:0] sL;
    logic [3:0] sR;
    logic       page;
    logic       edit;
    logic [1:0] edit_digit;

    modport master (output fmt, hrL, hrR, mL, mR, sL, sR, page, edit, edit_digit);
    modport slave  (input  fmt, hrL, hrR, mL, mR, sL, sR, page, edit, edit_digit);
endinterface

// File: rtl/seg7_time_display_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 decode to a dash.
module bcd_to_seg7
    import seg7_time_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_time_display.sv
// Scans a 4-digit common-anode display showing HH.MM or MM.SS with optional 12-h conversion.
// Define EDIT_BLINK_EN to build the edit-digit blink logic.
module seg7_time_display
    import seg7_time_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 50000000
) (
    input  logic                      clk,
    input  logic                      rst,
    seg7_time_display_if.slave        bus,
    output logic [3:0]                an,
    output logic [6:0]                seg,
    output logic                      dp
);

    localparam int unsigned RW = $clog2(REFRESH_DIV + 1);

    logic [RW-1:0] refresh_cnt;
    logic [1:0]    scan_idx;
    logic          load_pending;
    snap_t         snap;
    logic          refresh_tc;

    logic [5:0] hour_raw;
    logic [5:0] hour_disp;
    logic       hour_bad;
    logic       pm;
    logic [3:0] hr_tens;
    logic [3:0] hr_units;
    logic [3:0] slot_digit;
    logic [6:0] slot_seg;
    logic       lead_blank;
    logic       blink_blank;
    logic       blank;
    logic [3:0] an_c;
    logic [6:0] seg_c;
    logic       dp_c;

    assign refresh_tc = (refresh_cnt == RW'(REFRESH_DIV - 1));

    // Scan counters, frame snapshot and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt  <= '0;
            scan_idx     <= '0;
            load_pending <= 1'b1;
            snap         <= '0;
            an           <= 4'hF;
            seg          <= SEG_BLANK;
            dp           <= 1'b1;
        end else begin
            load_pending <= 1'b0;
            if (refresh_tc) begin
                refresh_cnt <= '0;
                scan_idx    <= scan_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + RW'(1);
            end
            if (load_pending || (refresh_tc && scan_idx == SLOT_3)) begin
                snap <= {bus.fmt, bus.page, bus.hrL, bus.hrR, bus.mL, bus.mR, bus.sL, bus.sR};
            end
            an  <= an_c;
            seg <= seg_c;
            dp  <= dp_c;
        end
    end

    // Hour validation and 24-h to 12-h conversion
    always_comb begin
        hour_raw  = 6'(snap.hrL) * 6'd10 + 6'(snap.hrR);
        hour_bad  = (hour_raw > 6'd23) || (snap.hrR > 4'd9);
        pm        = !hour_bad && (hour_raw >= 6'd12);
        hour_disp = hour_raw;
        if (snap.fmt) begin
            if (hour_raw == 6'd0) begin
                hour_disp = 6'd12;
            end else if (hour_raw > 6'd12) begin
                hour_disp = hour_raw - 6'd12;
            end
        end
        if (hour_bad) begin
            hr_tens  = BCD_BAD;
            hr_units = BCD_BAD;
        end else if (hour_disp >= 6'd20) begin
            hr_tens  = 4'd2;
            hr_units = 4'(hour_disp - 6'd20);
        end else if (hour_disp >= 6'd10) begin
            hr_tens  = 4'd1;
            hr_units = 4'(hour_disp - 6'd10);
        end else begin
            hr_tens  = 4'd0;
            hr_units = 4'(hour_disp);
        end
    end

    always_comb begin
        slot_digit = snap.mR;
        if (snap.page == PAGE_MS) begin
            case (scan_idx)
                SLOT_3:  slot_digit = 4'(snap.mL);
                SLOT_2:  slot_digit = snap.mR;
                SLOT_1:  slot_digit = 4'(snap.sL);
                default: slot_digit = snap.sR;
            endcase
        end else begin
            case (scan_idx)
                SLOT_3:  slot_digit = hr_tens;
                SLOT_2:  slot_digit = hr_units;
                SLOT_1:  slot_digit = 4'(snap.mL);
                default: slot_digit = snap.mR;
            endcase
        end
    end

    bcd_to_seg7 u_dec (
        .bcd   (slot_digit),
        .seg_c (slot_seg)
    );

`ifdef EDIT_BLINK_EN
    localparam int unsigned BW = $clog2(BLINK_DIV + 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic          edit_q;
    logic [1:0]    edit_digit_q;
    logic          blink_restart;

    assign blink_restart = (bus.edit && !edit_q) || (bus.edit_digit != edit_digit_q);

    // Blink phase; restarting in the visible phase keeps the newly selected digit readable
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt    <= '0;
            blink_on     <= 1'b1;
            edit_q       <= 1'b0;
            edit_digit_q <= 2'd0;
        end else begin
            edit_q       <= bus.edit;
            edit_digit_q <= bus.edit_digit;
            if (blink_restart) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_on  <= !blink_on;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    assign blink_blank = bus.edit && (snap.page == PAGE_HM) && !blink_on
                         && (scan_idx == (2'd3 - bus.edit_digit));
`else
    localparam int unsigned unused_blink_div = BLINK_DIV;
    logic unused_edit;
    assign unused_edit = ^{bus.edit, bus.edit_digit};
    assign blink_blank = 1'b0;
`endif

    // A blanked slot is fully dark: anode, segments and point all off
    always_comb begin
        lead_blank = snap.fmt && (snap.page == PAGE_HM) && !hour_bad
                     && (hr_tens == 4'd0) && (scan_idx == SLOT_3);
        blank = lead_blank || blink_blank;
        an_c  = blank ? 4'hF : ~(4'b0001 << scan_idx);
        seg_c = blank ? SEG_BLANK : slot_seg;
        dp_c  = blank || !((scan_idx == SLOT_2)
                           || ((snap.page == PAGE_HM) && (scan_idx == SLOT_0) && snap.fmt && pm));
    end

endmodule

// File: tb/tb_seg7_time_display.sv
// Self-checking bench for seg7_time_display against a cycle-indexed behavioural model.
module tb_seg7_time_display;

    localparam int unsigned REFRESH_DIV = 4;
    localparam int unsigned BLINK_DIV   = 8;
    localparam int          FRAME       = 4 * REFRESH_DIV;

    typedef struct {
        int fmt;
        int page;
        int hrL;
        int hrR;
        int mL;
        int mR;
        int sL;
        int sR;
    } time_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int    vectors;
    int    miscompares;
    int    k;
    int    restart_at;
    int    prev_edit;
    int    prev_digit;
    time_t model_snap;

    seg7_time_display_if bus ();

    seg7_time_display #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLINK_DIV   (BLINK_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .an  (an),
        .seg (seg),
        .dp  (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_code(input int d);
        case (d)
            0:       return 7'h40;
            1:       return 7'h79;
            2:       return 7'h24;
            3:       return 7'h30;
            4:       return 7'h19;
            5:       return 7'h12;
            6:       return 7'h02;
            7:       return 7'h78;
            8:       return 7'h00;
            9:       return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Expected {an, seg, dp} for a slot, derived from the display rules with plain arithmetic
    function automatic logic [11:0] expect_out(input time_t s, input int idx, input bit blink_on,
                                               input int edit, input int edit_digit);
        int         h;
        int         dh;
        int         digits[4];
        bit         bad;
        bit         pm;
        bit         blank;
        logic [3:0] a;
        logic       p;
        h   = 10 * s.hrL + s.hrR;
        bad = (h > 23) || (s.hrR > 9);
        pm  = !bad && (h >= 12);
        dh  = h;
        if (s.fmt != 0) dh = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
        if (s.page == 0) begin
            digits[3] = bad ? 15 : dh / 10;
            digits[2] = bad ? 15 : dh % 10;
            digits[1] = s.mL;
            digits[0] = s.mR;
        end else begin
            digits[3] = s.mL;
            digits[2] = s.mR;
            digits[1] = s.sL;
            digits[0] = s.sR;
        end
        blank = (s.fmt != 0) && (s.page == 0) && !bad && (dh < 10) && (idx == 3);
`ifdef EDIT_BLINK_EN
        if ((edit != 0) && (s.page == 0) && !blink_on && (idx == 3 - edit_digit)) blank = 1'b1;
`else
        if ((edit + edit_digit) < 0 || blink_on) blank = blank;
`endif
        if (blank) return {4'hF, 7'h7F, 1'b1};
        a      = 4'hF;
        a[idx] = 1'b0;
        p      = !((idx == 2) || ((s.page == 0) && (idx == 0) && (s.fmt != 0) && pm));
        return {a, seg_code(digits[idx]), p};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic current_inputs(output time_t t);
        t.fmt  = int'(bus.fmt);
        t.page = int'(bus.page);
        t.hrL  = int'(bus.hrL);
        t.hrR  = int'(bus.hrR);
        t.mL   = int'(bus.mL);
        t.mR   = int'(bus.mR);
        t.sL   = int'(bus.sL);
        t.sR   = int'(bus.sR);
    endtask

    // One clock: predict from the state before the edge, advance the model, then compare
    task automatic step();
        logic [11:0] exp;
        bit          bon;
        time_t       cur;
        @(posedge clk);
        k++;
        current_inputs(cur);
        bon = (((k - 1 - restart_at) / BLINK_DIV) % 2) == 0;
        exp = expect_out(model_snap, ((k - 1) / REFRESH_DIV) % 4, bon,
                         int'(bus.edit), int'(bus.edit_digit));
        if (k == 1 || (k % FRAME) == 0) model_snap = cur;
        if ((bus.edit && prev_edit == 0) || int'(bus.edit_digit) != prev_digit) restart_at = k;
        prev_edit  = int'(bus.edit);
        prev_digit = int'(bus.edit_digit);
        #1;
        check("an",  7'(an),  7'(exp[11:8]));
        check("seg", seg,     exp[7:1]);
        check("dp",  7'(dp),  7'(exp[0]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_time(input int fmt, input int hrL, input int hrR, input int mL,
                            input int mR, input int sL, input int sR, input int page);
        bus.fmt  = 1'(fmt);
        bus.hrL  = 2'(hrL);
        bus.hrR  = 4'(hrR);
        bus.mL   = 3'(mL);
        bus.mR   = 4'(mR);
        bus.sL   = 3'(sL);
        bus.sR   = 4'(sR);
        bus.page = 1'(page);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        k           = 0;
        restart_at  = 0;
        prev_edit   = 0;
        prev_digit  = 0;
        model_snap  = '{0, 0, 0, 0, 0, 0, 0, 0};
        rst         = 1'b1;
        bus.edit       = 1'b0;
        bus.edit_digit = 2'd0;
        set_time(0, 1, 3, 4, 5, 2, 7, 0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_an",  7'(an), 7'h0F);
        check("rst_seg", seg,    7'h7F);
        check("rst_dp",  7'(dp), 7'h01);
        rst = 1'b0;

        // 24-h 13:45, then 12-h early-morning and afternoon hours
        run(2 * FRAME + 8);
        set_time(1, 0, 0, 0, 7, 0, 0, 0);
        run(2 * FRAME);
        set_time(1, 1, 3, 0, 5, 0, 0, 0);
        run(2 * FRAME);

        // Minute change in the middle of a frame must wait for the next frame
        for (int i = 0; i < FRAME && (k % FRAME) != 6; i++) step();
        bus.mR = 4'd6;
        run(2 * FRAME);

        // Invalid hour and invalid minute digit, then the MM.SS page
        set_time(0, 2, 7, 3, 5, 1, 9, 0);
        run(2 * FRAME);
        set_time(0, 1, 2, 4, 12, 5, 8, 0);
        run(2 * FRAME);
        set_time(1, 2, 2, 5, 9, 3, 1, 1);
        run(2 * FRAME);

        // Edit mode on the minute tens, then move to minute units
        set_time(0, 1, 2, 3, 4, 5, 6, 0);
        bus.edit       = 1'b1;
        bus.edit_digit = 2'd2;
        run(3 * FRAME);
        bus.edit_digit = 2'd3;
        run(3 * FRAME);
        bus.edit = 1'b0;
        run(FRAME);

        // Randomised inputs held for random durations
        for (int r = 0; r < 40; r++) begin
            bus.fmt  = 1'($urandom_range(0, 1));
            bus.page = 1'($urandom_range(0, 1));
            bus.hrL  = 2'($urandom_range(0, 3));
            bus.hrR  = 4'(($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9));
            bus.mL   = 3'($urandom_range(0, 7));
            bus.mR   = 4'(($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9));
            bus.sL   = 3'($urandom_range(0, 5));
            bus.sR   = 4'($urandom_range(0, 9));
            bus.edit       = 1'($urandom_range(0, 1));
            bus.edit_digit = 2'($urandom_range(0, 3));
            run(int'($urandom_range(1, 40)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
